// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the Wishbone-to-MAC register-file bridge.
// Holds the FSM encoding, the default register map limits and the access-legality check.
package reg_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_RD   = 3'd2,
      ST_CAP  = 3'd3,
      ST_ACK  = 3'd4,
      ST_ERR  = 3'd5
   } state_e;

   localparam int unsigned IDX_MAX_DEF = 34;
   localparam int unsigned RO_LO_DEF   = 30;
   localparam int unsigned RO_HI_DEF   = 32;

   localparam logic [1:0] SEL_LEGAL = 2'b11;

   // An access is refused for partial byte lanes, an unimplemented word, or a write to a read-only word.
   function automatic logic access_illegal(
      input logic       we,
      input logic [6:0] idx,
      input logic [1:0] sel,
      input logic [6:0] idx_max,
      input logic [6:0] ro_lo,
      input logic [6:0] ro_hi
   );
      logic bad_sel;
      logic bad_idx;
      logic bad_ro;
      bad_sel = (sel != SEL_LEGAL);
      bad_idx = (idx > idx_max);
      bad_ro  = we && (idx >= ro_lo) && (idx <= ro_hi);
      return bad_sel || bad_idx || bad_ro;
   endfunction

endpackage

// File: rtl/reg_bus_bridge.sv
// Wishbone-classic slave that turns each single WB cycle into one MAC register-file access.
// Every cycle ends in ack or err; an aborted cycle still completes its register strobe silently.
module reg_bus_bridge
   import reg_bus_pkg::*;
#(
   parameter int unsigned IDX_MAX = IDX_MAX_DEF,
   parameter int unsigned RO_LO   = RO_LO_DEF,
   parameter int unsigned RO_HI   = RO_HI_DEF
) (
   input  logic        Clk_reg,
   input  logic        Reset,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [7:0]  wb_adr_i,
   input  logic [1:0]  wb_sel_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        CSB,
   output logic        WRB,
   output logic [7:0]  CA,
   output logic [15:0] CD_in,
   input  logic [15:0] CD_out
);

   localparam logic [6:0] IDX_MAX_W = 7'(IDX_MAX);
   localparam logic [6:0] RO_LO_W   = 7'(RO_LO);
   localparam logic [6:0] RO_HI_W   = 7'(RO_HI);

   state_e      state_q, state_d;
   logic        csb_q, csb_d;
   logic        wrb_q, wrb_d;
   logic [7:0]  ca_q, ca_d;
   logic [15:0] cd_in_q, cd_in_d;
   logic [15:0] dat_q, dat_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic        abort_q, abort_d;
   logic        cyc_lost_s;

   assign cyc_lost_s = abort_q | ~wb_cyc_i;

   // Next-state and next-output decode; outputs are computed one state ahead so they leave flops.
   always_comb begin
      state_d = state_q;
      csb_d   = 1'b1;
      wrb_d   = 1'b1;
      ca_d    = ca_q;
      cd_in_d = cd_in_q;
      dat_d   = dat_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      abort_d = abort_q;
      case (state_q)
         ST_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               // Byte lane bit has no meaning on a 16-bit word bus and is forced to zero.
               ca_d    = {wb_adr_i[7:1], wb_adr_i[0] & 1'b0};
               cd_in_d = wb_dat_i;
               abort_d = 1'b0;
               if (access_illegal(wb_we_i, wb_adr_i[7:1], wb_sel_i, IDX_MAX_W, RO_LO_W, RO_HI_W)) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else if (wb_we_i) begin
                  state_d = ST_WR;
                  csb_d   = 1'b0;
                  wrb_d   = 1'b0;
               end else begin
                  state_d = ST_RD;
                  csb_d   = 1'b0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WR: begin
            abort_d = cyc_lost_s;
            state_d = ST_ACK;
            ack_d   = ~cyc_lost_s;
         end
         ST_RD: begin
            abort_d = cyc_lost_s;
            state_d = ST_CAP;
         end
         ST_CAP: begin
            abort_d = cyc_lost_s;
            dat_d   = CD_out;
            state_d = ST_ACK;
            ack_d   = ~cyc_lost_s;
         end
         ST_ACK:  state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge Clk_reg or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         csb_q   <= 1'b1;
         wrb_q   <= 1'b1;
         ca_q    <= 8'h00;
         cd_in_q <= 16'h0000;
         dat_q   <= 16'h0000;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         csb_q   <= csb_d;
         wrb_q   <= wrb_d;
         ca_q    <= ca_d;
         cd_in_q <= cd_in_d;
         dat_q   <= dat_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         abort_q <= abort_d;
      end
   end

   assign wb_dat_o = dat_q;
   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign CSB      = csb_q;
   assign WRB      = wrb_q;
   assign CA       = ca_q;
   assign CD_in    = cd_in_q;

endmodule

// File: tb/tb_reg_bus_bridge.sv
// Randomized bench for reg_bus_bridge with a register-file device model and a transaction-level scoreboard.
module tb_reg_bus_bridge;

   logic        clk_reg;
   logic        reset;
   logic        cyc_i, stb_i, we_i;
   logic [7:0]  adr_i;
   logic [1:0]  sel_i;
   logic [15:0] dat_i;
   logic [15:0] dat_o;
   logic        ack_o, err_o;
   logic        csb, wrb;
   logic [7:0]  ca;
   logic [15:0] cd_in;
   logic [15:0] cd_out;

   int n_vec = 0;
   int n_mis = 0;

   logic [15:0] rf     [0:34];
   logic [15:0] exp_rf [0:34];
   logic [15:0] last_rd;
   bit          last_rd_valid;

   reg_bus_bridge dut (
      .Clk_reg (clk_reg),
      .Reset   (reset),
      .wb_cyc_i(cyc_i),
      .wb_stb_i(stb_i),
      .wb_we_i (we_i),
      .wb_adr_i(adr_i),
      .wb_sel_i(sel_i),
      .wb_dat_i(dat_i),
      .wb_dat_o(dat_o),
      .wb_ack_o(ack_o),
      .wb_err_o(err_o),
      .CSB     (csb),
      .WRB     (wrb),
      .CA      (ca),
      .CD_in   (cd_in),
      .CD_out  (cd_out)
   );

   initial clk_reg = 1'b0;
   always #5 clk_reg = ~clk_reg;

   // Register file as the MAC presents it: registered read data, zero unless a read strobe occurred.
   initial begin
      for (int i = 0; i <= 34; i++) rf[i] <= 16'h0100 + 16'(i);
      rf[26] <= 16'h2710;
      cd_out <= 16'h0000;
   end

   always @(posedge clk_reg) begin
      if (!csb && wrb && ca[7:1] <= 7'd34) cd_out <= rf[ca[7:1]];
      else if (!csb && wrb)                cd_out <= 16'hDEAD;
      else                                 cd_out <= 16'h0000;
      if (!csb && !wrb && ca[7:1] <= 7'd34) rf[ca[7:1]] <= cd_in;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_txn(input logic we, input logic [7:0] adr, input logic [1:0] sel,
                          input logic [15:0] dat, input bit abort);
      logic [6:0]  idx;
      bit          bad;
      int          exp_lat, ack_at, err_at, n_ack, n_err, n_csb, n_wr, n_bad_wrb;
      logic [7:0]  ca_seen;
      logic [15:0] cd_seen, dat_seen;
      idx = adr[7:1];
      bad = (sel != 2'b11) || (idx > 7'd34) || (we && idx >= 7'd30 && idx <= 7'd32);
      exp_lat = bad ? 1 : (we ? 2 : 3);
      ack_at = 0; err_at = 0; n_ack = 0; n_err = 0; n_csb = 0; n_wr = 0; n_bad_wrb = 0;
      ca_seen = 8'h00; cd_seen = 16'h0000; dat_seen = 16'h0000;
      @(negedge clk_reg);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
      @(posedge clk_reg);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk_reg);
         if (!csb) begin
            n_csb++;
            ca_seen = ca;
            cd_seen = cd_in;
            if (!wrb) n_wr++;
         end else if (!wrb) begin
            n_bad_wrb++;
         end
         if (ack_o) begin
            n_ack++;
            if (ack_at == 0) ack_at = k;
            dat_seen = dat_o;
         end
         if (err_o) begin
            n_err++;
            if (err_at == 0) err_at = k;
         end
         // Strobe is held through the whole ack/err cycle and released only after it was seen.
         if (ack_o || err_o || (abort && k == 1)) begin
            cyc_i = 1'b0; stb_i = 1'b0;
         end
      end
      cyc_i = 1'b0; stb_i = 1'b0;
      if (abort && !bad) begin
         chk("abort_ack", 32'(n_ack), 32'd0);
         chk("abort_err", 32'(n_err), 32'd0);
         chk("abort_csb", 32'(n_csb), 32'd1);
      end else begin
         chk("latency", 32'(bad ? err_at : ack_at), 32'(exp_lat));
         chk("ack_cnt", 32'(n_ack), bad ? 32'd0 : 32'd1);
         chk("err_cnt", 32'(n_err), bad ? 32'd1 : 32'd0);
         chk("csb_cnt", 32'(n_csb), bad ? 32'd0 : 32'd1);
      end
      chk("wr_cnt", 32'(n_wr), (!bad && we) ? 32'd1 : 32'd0);
      chk("wrb_wo_csb", 32'(n_bad_wrb), 32'd0);
      if (!bad) begin
         chk("ca", 32'(ca_seen), 32'({idx, 1'b0}));
         if (we) chk("cd_in", 32'(cd_seen), 32'(dat));
      end
      if (!bad && !we && !abort) begin
         chk("rd_data", 32'(dat_seen), 32'(exp_rf[idx]));
         last_rd = exp_rf[idx];
         last_rd_valid = 1'b1;
      end else if (!bad && !we && abort) begin
         last_rd_valid = 1'b0;
      end else if (last_rd_valid) begin
         chk("dat_hold", 32'(dat_o), 32'(last_rd));
      end
      if (!bad && we) exp_rf[idx] = dat;
   endtask

   initial begin
      for (int i = 0; i <= 34; i++) exp_rf[i] = 16'h0100 + 16'(i);
      exp_rf[26] = 16'h2710;
      last_rd = 16'h0000;
      last_rd_valid = 1'b1;
      reset = 1'b1;
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      adr_i = 8'h00; sel_i = 2'b11; dat_i = 16'h0000;
      repeat (2) @(negedge clk_reg);
      chk("rst_csb", 32'(csb), 32'd1);
      chk("rst_wrb", 32'(wrb), 32'd1);
      chk("rst_ca", 32'(ca), 32'd0);
      chk("rst_cd_in", 32'(cd_in), 32'd0);
      chk("rst_dat_o", 32'(dat_o), 32'd0);
      chk("rst_ack_err", 32'({ack_o, err_o}), 32'd0);
      reset = 1'b0;
      @(negedge clk_reg);

      run_txn(1'b0, 8'h34, 2'b11, 16'h0000, 1'b0);
      run_txn(1'b1, 8'h00, 2'b11, 16'h0012, 1'b0);
      run_txn(1'b0, 8'h00, 2'b11, 16'h0000, 1'b0);
      run_txn(1'b1, 8'h3E, 2'b11, 16'hBEEF, 1'b0);
      run_txn(1'b1, 8'h46, 2'b11, 16'hBEEF, 1'b0);
      run_txn(1'b0, 8'h10, 2'b01, 16'h0000, 1'b0);
      run_txn(1'b0, 8'h3E, 2'b11, 16'h0000, 1'b0);
      run_txn(1'b0, 8'h0A, 2'b11, 16'h0000, 1'b1);
      run_txn(1'b0, 8'h0A, 2'b11, 16'h0000, 1'b0);

      for (int n = 0; n < 60; n++) begin
         logic [6:0]  r_idx;
         logic [1:0]  r_sel;
         logic [7:0]  r_adr;
         r_idx = 7'($urandom_range(0, 40));
         r_sel = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         r_adr = {r_idx, 1'($urandom_range(0, 1))};
         run_txn(1'($urandom_range(0, 1)), r_adr, r_sel, 16'($urandom), ($urandom_range(0, 9) == 0));
      end

      // Reset while the read strobe is on the bus.
      @(negedge clk_reg);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 8'h0A; sel_i = 2'b11;
      @(posedge clk_reg);
      @(negedge clk_reg);
      chk("pre_rst_csb", 32'(csb), 32'd0);
      reset = 1'b1;
      #1;
      chk("midrst_csb", 32'(csb), 32'd1);
      chk("midrst_wrb", 32'(wrb), 32'd1);
      chk("midrst_ack_err", 32'({ack_o, err_o}), 32'd0);
      @(negedge clk_reg);
      cyc_i = 1'b0; stb_i = 1'b0;
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk_reg);
         chk("post_rst_quiet", 32'({csb, ack_o, err_o}), 32'b100);
      end
      last_rd = 16'h0000;
      last_rd_valid = 1'b1;
      run_txn(1'b1, 8'h06, 2'b11, 16'hA5C3, 1'b0);
      run_txn(1'b0, 8'h06, 2'b11, 16'h0000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
